// File: rtl/fifo_feeder_tx_if.sv
// Producer/phy-side bundle for the four-lane transmit feeder.
// The master side pushes bytes and drives phy_ready; the slave side is the feeder.
interface fifo_feeder_tx_if #(
    parameter int DATA_W = 8
);
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          push;
    logic                phy_ready;
    logic [DATA_W-1:0]   in0_tx;
    logic [DATA_W-1:0]   in1_tx;
    logic [DATA_W-1:0]   in2_tx;
    logic [DATA_W-1:0]   in3_tx;
    logic                valid_in0_tx;
    logic                valid_in1_tx;
    logic                valid_in2_tx;
    logic                valid_in3_tx;
    logic [3:0]          full;
    logic [3:0]          empty;
    logic [3:0]          almost_full;
    logic [3:0]          almost_empty;
    logic [3:0]          err_ovf;
    logic [1:0]          state;

    modport master (
        output data_in, push, phy_ready,
        input  in0_tx, in1_tx, in2_tx, in3_tx,
        input  valid_in0_tx, valid_in1_tx, valid_in2_tx, valid_in3_tx,
        input  full, empty, almost_full, almost_empty, err_ovf, state
    );

    modport slave (
        input  data_in, push, phy_ready,
        output in0_tx, in1_tx, in2_tx, in3_tx,
        output valid_in0_tx, valid_in1_tx, valid_in2_tx, valid_in3_tx,
        output full, empty, almost_full, almost_empty, err_ovf, state
    );
endinterface

// File: rtl/fifo_feeder_tx.sv
// Four independent byte FIFOs draining into registered phy lanes,
// gated by phy_ready and a small IDLE/ACTIVE/PAUSE controller.
module fifo_feeder_tx #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input logic               clk_f,
    input logic               reset,
    fifo_feeder_tx_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        PAUSE  = 2'b10
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem    [4][DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr [4];
    logic [ADDR_W-1:0] r_rd_ptr [4];
    logic [CW-1:0]     r_count  [4];
    logic [DATA_W-1:0] r_tx     [4];
    logic [3:0]        r_valid;
    logic [3:0]        r_err;

    logic [3:0] w_full;
    logic [3:0] w_empty;
    logic [3:0] w_afull;
    logic [3:0] w_aempty;
    logic [3:0] w_pop;
    logic [3:0] w_wr;
    logic [3:0] w_ovf;

    always_comb begin
        w_full   = '0;
        w_empty  = '0;
        w_afull  = '0;
        w_aempty = '0;
        w_pop    = '0;
        w_wr     = '0;
        w_ovf    = '0;
        for (int i = 0; i < 4; i++) begin
            w_full[i]   = r_count[i] == CW'(DEPTH);
            w_empty[i]  = r_count[i] == '0;
            w_afull[i]  = r_count[i] >= CW'(AFULL_TH);
            w_aempty[i] = r_count[i] <= CW'(AEMPTY_TH);
            w_pop[i]    = (r_state != PAUSE) & bus.phy_ready & ~w_empty[i];
            // A full lane still accepts a byte when it pops the same cycle
            w_wr[i]     = bus.push[i] & (~w_full[i] | w_pop[i]);
            w_ovf[i]    = bus.push[i] & w_full[i] & ~w_pop[i];
        end
    end

    always_ff @(posedge clk_f) begin
        for (int i = 0; i < 4; i++) begin
            if (w_wr[i])
                r_mem[i][r_wr_ptr[i]] <= bus.data_in[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
                r_tx[i]     <= '0;
            end
            r_valid <= '0;
            r_err   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr[i])
                    r_wr_ptr[i] <= r_wr_ptr[i] + ADDR_W'(1);
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + ADDR_W'(1);
                    r_tx[i]     <= r_mem[i][r_rd_ptr[i]];
                end
                if (w_wr[i] && !w_pop[i])
                    r_count[i] <= r_count[i] + CW'(1);
                else if (!w_wr[i] && w_pop[i])
                    r_count[i] <= r_count[i] - CW'(1);
            end
            r_valid <= w_pop;
            r_err   <= r_err | w_ovf;
        end
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE:
                    if (!(&w_empty) && bus.phy_ready)
                        r_state <= ACTIVE;
                ACTIVE:
                    if (!bus.phy_ready)
                        r_state <= PAUSE;
                    else if (&w_empty && bus.push == 4'b0)
                        r_state <= IDLE;
                PAUSE:
                    if (bus.phy_ready)
                        r_state <= ACTIVE;
                default:
                    r_state <= IDLE;
            endcase
        end
    end

    assign bus.in0_tx       = r_tx[0];
    assign bus.in1_tx       = r_tx[1];
    assign bus.in2_tx       = r_tx[2];
    assign bus.in3_tx       = r_tx[3];
    assign bus.valid_in0_tx = r_valid[0];
    assign bus.valid_in1_tx = r_valid[1];
    assign bus.valid_in2_tx = r_valid[2];
    assign bus.valid_in3_tx = r_valid[3];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = w_afull;
    assign bus.almost_empty = w_aempty;
    assign bus.err_ovf      = r_err;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_fifo_feeder_tx.sv
// Scoreboard bench for fifo_feeder_tx: queue-based lane model feeds
// expected bytes; a negedge monitor compares every lane and status output.
module tb_fifo_feeder_tx;
    logic clk_f = 1'b0;
    logic reset = 1'b0;

    fifo_feeder_tx_if #(.DATA_W(8)) bus ();

    fifo_feeder_tx dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_f = ~clk_f;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mq [4][$];
    logic [7:0] eq [4][$];
    logic [3:0] m_valid;
    logic [3:0] m_err;
    int         m_state;

    logic [7:0] tx [4];
    logic [3:0] vld;
    assign tx[0] = bus.in0_tx;
    assign tx[1] = bus.in1_tx;
    assign tx[2] = bus.in2_tx;
    assign tx[3] = bus.in3_tx;
    assign vld   = {bus.valid_in3_tx, bus.valid_in2_tx,
                    bus.valid_in1_tx, bus.valid_in0_tx};

    task automatic chk(input string nm, input int ln,
                       input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s lane%0d: got %0h expected %0h", nm, ln, act, exp);
        end
    endtask

    // Reference: each lane is a 4-deep queue; the phy takes the head byte
    // whenever it is ready and the feeder is not paused.
    always @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                eq[i].delete();
            end
            m_valid = '0;
            m_err   = '0;
            m_state = 0;
        end else begin
            automatic bit any_data = 0;
            automatic bit pr = bus.phy_ready;
            automatic logic [3:0] ps = bus.push;
            automatic logic [31:0] din = bus.data_in;
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0) any_data = 1;
            for (int i = 0; i < 4; i++) begin
                automatic bit was_full = mq[i].size() == 4;
                automatic bit take = (m_state != 2) && pr && mq[i].size() != 0;
                if (take) eq[i].push_back(mq[i].pop_front());
                m_valid[i] = take;
                if (ps[i]) begin
                    if (!was_full || take) mq[i].push_back(din[i*8 +: 8]);
                    else m_err[i] = 1'b1;
                end
            end
            case (m_state)
                0: if (any_data && pr) m_state = 1;
                1: if (!pr) m_state = 2;
                   else if (!any_data && ps == 4'b0) m_state = 0;
                2: if (pr) m_state = 1;
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk_f) begin
        logic [3:0] e_full, e_empty, e_af, e_ae;
        for (int i = 0; i < 4; i++) begin
            chk("valid", i, 32'(vld[i]), 32'(m_valid[i]));
            if (vld[i]) begin
                if (eq[i].size() == 0)
                    chk("unexpected_byte", i, 32'(tx[i]), 32'hFFFF_FFFF);
                else
                    chk("data", i, 32'(tx[i]), 32'(eq[i].pop_front()));
            end else if (eq[i].size() != 0) begin
                void'(eq[i].pop_front());
            end
            e_full[i]  = mq[i].size() == 4;
            e_empty[i] = mq[i].size() == 0;
            e_af[i]    = mq[i].size() >= 3;
            e_ae[i]    = mq[i].size() <= 1;
        end
        chk("full", 0, 32'(bus.full), 32'(e_full));
        chk("empty", 0, 32'(bus.empty), 32'(e_empty));
        chk("almost_full", 0, 32'(bus.almost_full), 32'(e_af));
        chk("almost_empty", 0, 32'(bus.almost_empty), 32'(e_ae));
        chk("err_ovf", 0, 32'(bus.err_ovf), 32'(m_err));
        chk("state", 0, 32'(bus.state), 32'(m_state));
    end

    task automatic cyc(input logic [3:0] p, input logic [31:0] d, input logic pr);
        @(posedge clk_f);
        #1;
        bus.push      = p;
        bus.data_in   = d;
        bus.phy_ready = pr;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout lane0: got 0 expected 1");
        $fatal(1);
    end

    initial begin
        bus.push      = '0;
        bus.data_in   = '0;
        bus.phy_ready = 1'b0;
        #12 reset = 1'b1;
        cyc(4'b0, 32'h0, 1'b1);

        // latency: byte visible exactly one edge after the push edge
        cyc(4'b0001, 32'h0000_00A5, 1'b1);
        cyc(4'b0000, 32'h0, 1'b1);
        @(posedge clk_f);
        #1;
        chk("lat_valid", 0, 32'(bus.valid_in0_tx), 32'h1);
        chk("lat_data", 0, 32'(bus.in0_tx), 32'hA5);
        chk("lat_state", 0, 32'(bus.state), 32'h1);
        repeat (3) cyc(4'b0, 32'h0, 1'b1);

        // order and pointer wrap on lane 2
        for (int k = 1; k <= 10; k++)
            cyc(4'b0100, 32'(k) << 16, 1'b1);
        repeat (4) cyc(4'b0, 32'h0, 1'b1);

        // overflow on lane 1 while phy is stalled
        for (int k = 0; k < 5; k++)
            cyc(4'b0010, 32'(8'h10 + k) << 8, 1'b0);
        cyc(4'b0, 32'h0, 1'b0);
        @(negedge clk_f);
        chk("ovf_full", 1, 32'(bus.full[1]), 32'h1);
        chk("ovf_err", 1, 32'(bus.err_ovf[1]), 32'h1);
        repeat (6) cyc(4'b0, 32'h0, 1'b1);

        // full lane 3 push while popping
        for (int k = 0; k < 4; k++)
            cyc(4'b1000, 32'(8'h30 + k) << 24, 1'b0);
        cyc(4'b1000, 32'h7700_0000, 1'b1);
        cyc(4'b0, 32'h0, 1'b1);
        @(negedge clk_f);
        chk("fullpp_err", 3, 32'(bus.err_ovf[3]), 32'h0);
        repeat (6) cyc(4'b0, 32'h0, 1'b1);

        // pause in the middle of a four-lane burst
        cyc(4'b1111, 32'h4030_2010, 1'b1);
        cyc(4'b1111, 32'h4131_2111, 1'b1);
        cyc(4'b1111, 32'h4232_2212, 1'b0);
        cyc(4'b0000, 32'h0, 1'b0);
        cyc(4'b0000, 32'h0, 1'b1);
        repeat (6) cyc(4'b0, 32'h0, 1'b1);

        // random traffic
        for (int n = 0; n < 300; n++)
            cyc(4'($urandom_range(0, 15)), $urandom(),
                $urandom_range(0, 9) < 7);

        // asynchronous reset mid-traffic, checked before any edge
        @(negedge clk_f);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_valid", 0, 32'(vld), 32'h0);
        chk("rst_empty", 0, 32'(bus.empty), 32'hF);
        chk("rst_err", 0, 32'(bus.err_ovf), 32'h0);
        chk("rst_state", 0, 32'(bus.state), 32'h0);
        cyc(4'b0, 32'h0, 1'b1);
        reset = 1'b1;

        for (int n = 0; n < 100; n++)
            cyc(4'($urandom_range(0, 15)), $urandom(),
                $urandom_range(0, 9) < 6);
        repeat (10) cyc(4'b0, 32'h0, 1'b1);
        @(negedge clk_f);
        #1;
        for (int i = 0; i < 4; i++)
            chk("drain", i, 32'(eq[i].size() + mq[i].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
